// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the MMU port arbiter.
//   arb_state_e : transaction sequencer states (idle, busy on fetch, busy on data, done)
//   arb_port_e  : requester identifiers for the fetch (I) and load/store (D) ports
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusyI = 2'd1,
    ArbBusyD = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ArbPortI = 1'b0,
    ArbPortD = 1'b1
  } arb_port_e;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Fetch starvation guard for mem_port_arbiter.
// Counts data-port grants made while a fetch is waiting and raises force_fetch once the
// count reaches STARVE_MAX. Any fetch grant clears the count.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   if_req       : fetch request level
//   d_grant      : data port granted this cycle
//   i_grant      : fetch port granted this cycle
//   force_fetch  : next arbitration must favour the fetch port
module mem_port_arbiter_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_grant,
  input  logic i_grant,
  output logic force_fetch
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntW'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (i_grant) begin
      cnt_d = '0;
    end else if (d_grant && if_req && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = at_max;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single MMU memory port between instruction fetch (I) and load/store (D).
// One transaction at a time: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE. D wins ties.
// Optional feature: define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX
// consecutive data grants made while a fetch was waiting.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   if_req/if_addr/if_flush          : fetch request, word address, cancel (branch taken)
//   if_ack/if_rdata                  : one-cycle fetch completion, instruction data
//   d_req/d_we/d_byte/d_addr/d_wdata : data request, store flag, byte select, address, data
//   d_ack/d_rdata                    : one-cycle data completion, raw load data
//   mem_req/mem_we/mem_byte/mem_addr/mem_wdata : MMU request, held until mem_ack
//   mem_ack/mem_rdata                : MMU completion and read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              flush_q, flush_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_byte_q, mem_byte_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic      i_pend;
  logic      force_fetch;
  logic      grant_i;
  logic      grant_d;
  arb_port_e winner;

  // A flush in the sampling cycle hides the fetch request from arbitration.
  assign i_pend  = if_req & ~if_flush;
  assign winner  = (i_pend && (!d_req || force_fetch)) ? ArbPortI : ArbPortD;
  assign grant_i = (state_q == ArbIdle) && (winner == ArbPortI);
  assign grant_d = (state_q == ArbIdle) && d_req && (winner == ArbPortD);

`ifdef ARB_STARVE_GUARD_EN
  mem_port_arbiter_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .d_grant     (grant_d),
    .i_grant     (grant_i),
    .force_fetch (force_fetch)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign force_fetch       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      ArbIdle: begin
        if (grant_d) begin
          state_d     = ArbBusyD;
          flush_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_byte_d  = d_byte;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = ArbBusyI;
          flush_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_byte_d  = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ArbBusyI: begin
        // The MMU request is never withdrawn; a flush only cancels the acknowledge.
        if (if_flush) begin
          flush_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = ArbDone;
          mem_req_d = 1'b0;
          if (!flush_q && !if_flush) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      ArbBusyD: begin
        if (mem_ack) begin
          state_d   = ArbDone;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ArbIdle;
      flush_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // A flush arriving in the DONE cycle still cancels the fetch acknowledge.
  assign if_ack    = if_ack_q & ~if_flush;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned SMax = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_byte, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMax)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_byte    (d_byte),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- MMU responder ----------------
  logic [31:0] mem [logic [31:0]];
  int  mem_lat = 3;
  bit  spur    = 1'b0;
  int  lat_cnt = 0;
  bit  ack_sent = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a) != 0) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    #2;
    mem_ack = 1'b0;
    if (mem_req !== 1'b1) begin
      lat_cnt  = 0;
      ack_sent = 1'b0;
      if (spur) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end
    end else if (!ack_sent) begin
      if (lat_cnt >= mem_lat) begin
        mem_ack  = 1'b1;
        ack_sent = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_byte ? {24'h0, mem_wdata[7:0]} : mem_wdata;
          mem_rdata     = 32'h0BAD_F00D;
        end else begin
          mem_rdata = mem_rd(mem_addr);
        end
      end else begin
        lat_cnt++;
      end
    end
  end

  // ---------------- transaction-level reference + per-cycle compare ----------------
  typedef enum int {PhFree, PhMem, PhFin} ph_e;
  ph_e         m_ph      = PhFree;
  bit          m_own_d   = 1'b0;
  bit          m_flushed = 1'b0;
  bit          m_we      = 1'b0;
  bit          m_byte    = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [31:0] m_rd      = '0;
  int          m_starve  = 0;
  bit          armed     = 1'b0;

  // Observation logs for the directed literal checks.
  logic [31:0] g_addr[$];
  logic [31:0] g_wdata[$];
  bit          g_we[$];
  bit          g_byte[$];
  bit          prev_req = 1'b0;
  int rise_cyc = 0, memack_cyc = 0, ifack_cyc = 0, dack_cyc = 0;
  int n_memack = 0, n_ifack = 0, n_dack = 0;
  bit seen_if_ack = 1'b0, seen_d_ack = 1'b0;

  always @(negedge clk) begin
    bit e_if, e_d, i_pend, take_i;
    cyc++;
    if (armed) begin
      e_if = (m_ph == PhFin) && !m_own_d && !m_flushed && !if_flush;
      e_d  = (m_ph == PhFin) && m_own_d;
      chk1("mem_req", mem_req, m_ph == PhMem);
      if (m_ph == PhMem) begin
        chk32("mem_addr", mem_addr, m_addr);
        chk1("mem_we", mem_we, m_we);
        chk1("mem_byte", mem_byte, m_byte);
        if (m_own_d) chk32("mem_wdata", mem_wdata, m_wdata);
      end
      chk1("if_ack", if_ack, e_if);
      chk1("d_ack", d_ack, e_d);
      if (e_if) chk32("if_rdata", if_rdata, m_rd);
      if (e_d) chk32("d_rdata", d_rdata, m_rd);
    end

    if (mem_req === 1'b1 && !prev_req) begin
      g_addr.push_back(mem_addr);
      g_wdata.push_back(mem_wdata);
      g_we.push_back(mem_we);
      g_byte.push_back(mem_byte);
      rise_cyc = cyc;
    end
    prev_req = (mem_req === 1'b1);
    if (mem_req === 1'b1 && mem_ack) begin
      n_memack++;
      memack_cyc = cyc;
    end
    if (if_ack === 1'b1) begin
      n_ifack++;
      ifack_cyc = cyc;
    end
    if (d_ack === 1'b1) begin
      n_dack++;
      dack_cyc = cyc;
    end
    seen_if_ack = (if_ack === 1'b1);
    seen_d_ack  = (d_ack === 1'b1);

    if (reset) begin
      m_ph      = PhFree;
      m_starve  = 0;
      m_flushed = 1'b0;
      armed     = 1'b1;
    end else begin
      case (m_ph)
        PhFree: begin
          i_pend = if_req && !if_flush;
          take_i = i_pend && (!d_req || (Guard && m_starve == int'(SMax)));
          if (take_i) begin
            m_ph = PhMem; m_own_d = 1'b0; m_addr = if_addr; m_we = 1'b0; m_byte = 1'b0;
            m_flushed = 1'b0; m_starve = 0;
          end else if (d_req) begin
            m_ph = PhMem; m_own_d = 1'b1; m_addr = d_addr; m_we = d_we; m_byte = d_byte;
            m_wdata = d_wdata; m_flushed = 1'b0;
            if (if_req && m_starve < int'(SMax)) m_starve++;
          end
        end
        PhMem: begin
          if (!m_own_d && if_flush) m_flushed = 1'b1;
          if (mem_ack) begin
            m_rd = mem_rdata;
            m_ph = PhFin;
          end
        end
        default: m_ph = PhFree;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  bit auto_drop = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (seen_if_ack) if_req = 1'b0;
      if (seen_d_ack) d_req = 1'b0;
    end
  endtask

  task automatic run_acks(input int want_i, input int want_d, input int budget, input string name);
    int b = budget;
    while ((n_ifack < want_i || n_dack < want_d) && b > 0) begin
      step();
      b--;
    end
    chk1(name, (n_ifack >= want_i) && (n_dack >= want_d), 1'b1);
  endtask

  task automatic run_grants(input int want, input int budget, input string name);
    int b = budget;
    while (g_addr.size() < want && b > 0) begin
      step();
      b--;
    end
    chk1(name, g_addr.size() >= want, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc, g0, i0, d0, a0;
    reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
    mem[32'h100] = 32'h00A00093;
    mem[32'h140] = 32'h00000013;
    mem[32'h180] = 32'h00000073;
    mem[32'h200] = 32'hDEADBEEF;
    repeat (3) step();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    step();

    // 1. fetch only
    mem_lat = 3; g0 = g_addr.size(); i0 = n_ifack;
    if_addr = 32'h100; if_req = 1'b1; req_cyc = cyc + 1;
    run_acks(i0 + 1, n_dack, 30, "t1_done");
    repeat (2) step();
    chk32("t1_req_to_memreq", 32'(rise_cyc - req_cyc), 32'd1);
    chk32("t1_memreq_to_memack", 32'(memack_cyc - rise_cyc), 32'd3);
    chk32("t1_memack_to_ifack", 32'(ifack_cyc - memack_cyc), 32'd1);
    chk32("t1_addr", g_addr[g0], 32'h100);
    chk1("t1_we", g_we[g0], 1'b0);
    chk32("t1_if_rdata", if_rdata, 32'h00A00093);
    chk32("t1_ack_count", 32'(n_ifack - i0), 32'd1);

    // 2. simultaneous fetch and load: D first
    mem_lat = 1; g0 = g_addr.size(); i0 = n_ifack; d0 = n_dack;
    if_addr = 32'h100; if_req = 1'b1;
    d_addr = 32'h200; d_we = 1'b0; d_byte = 1'b0; d_req = 1'b1;
    run_acks(i0 + 1, d0 + 1, 40, "t2_done");
    repeat (4) step();
    chk32("t2_first", g_addr[g0], 32'h200);
    chk32("t2_second", g_addr[g0+1], 32'h100);
    chk32("t2_grants", 32'(g_addr.size() - g0), 32'd2);
    chk32("t2_if_acks", 32'(n_ifack - i0), 32'd1);
    chk32("t2_d_acks", 32'(n_dack - d0), 32'd1);
    chk32("t2_d_rdata", d_rdata, 32'hDEADBEEF);
    chk32("t2_if_rdata", if_rdata, 32'h00A00093);

    // 3. byte store
    mem_lat = 2; g0 = g_addr.size(); d0 = n_dack;
    d_addr = 32'h3; d_we = 1'b1; d_byte = 1'b1; d_wdata = 32'hAB; d_req = 1'b1;
    run_acks(n_ifack, d0 + 1, 30, "t3_done");
    repeat (3) step();
    d_we = 1'b0; d_byte = 1'b0;
    chk32("t3_addr", g_addr[g0], 32'h3);
    chk1("t3_we", g_we[g0], 1'b1);
    chk1("t3_byte", g_byte[g0], 1'b1);
    chk32("t3_wdata", g_wdata[g0], 32'hAB);
    chk32("t3_d_acks", 32'(n_dack - d0), 32'd1);
    chk32("t3_ack_lat", 32'(memack_cyc - rise_cyc), 32'd2);

    // 4a. flush in idle hides the request; spurious mem_ack in idle is ignored
    g0 = g_addr.size(); i0 = n_ifack; d0 = n_dack;
    if_addr = 32'h100; if_req = 1'b1; if_flush = 1'b1;
    step();
    if_req = 1'b0; if_flush = 1'b0; spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    chk32("t4_idle_flush_grants", 32'(g_addr.size() - g0), 32'd0);
    chk32("t4_spur_acks", 32'(n_ifack - i0 + n_dack - d0), 32'd0);

    // 4b. flush during BUSY_I: transaction completes, no if_ack
    mem_lat = 3; g0 = g_addr.size(); i0 = n_ifack; a0 = n_memack;
    if_addr = 32'h180; if_req = 1'b1;
    run_grants(g0 + 1, 10, "t4_grant_seen");
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    repeat (8) step();
    chk32("t4_mem_done", 32'(n_memack - a0), 32'd1);
    chk32("t4_no_if_ack", 32'(n_ifack - i0), 32'd0);
    if_addr = 32'h140; if_req = 1'b1;
    run_acks(i0 + 1, n_dack, 30, "t4_refetch_done");
    repeat (2) step();
    chk32("t4_refetch_addr", g_addr[g_addr.size()-1], 32'h140);
    chk32("t4_refetch_rdata", if_rdata, 32'h00000013);

    // 5. reset during BUSY_D
    mem_lat = 10; g0 = g_addr.size();
    d_addr = 32'h200; d_req = 1'b1;
    run_grants(g0 + 1, 10, "t5_grant_seen");
    step();
    chk1("t5_req_before", mem_req, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    step();
    chk1("t5_req_after", mem_req, 1'b0);
    chk1("t5_if_ack", if_ack, 1'b0);
    chk1("t5_d_ack", d_ack, 1'b0);
    reset = 1'b0;
    repeat (3) step();
    chk32("t5_no_regrant", 32'(g_addr.size() - g0), 32'd1);
    mem_lat = 1; i0 = n_ifack;
    if_addr = 32'h100; if_req = 1'b1; req_cyc = cyc + 1;
    run_acks(i0 + 1, n_dack, 20, "t5_after_done");
    chk32("t5_idle_latency", 32'(rise_cyc - req_cyc), 32'd1);
    repeat (2) step();

    // 6. both requests held continuously
    mem_lat = 1; g0 = g_addr.size(); auto_drop = 1'b0;
    d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    run_grants(g0 + 5, 80, "t6_grants_seen");
    d_req = 1'b0; if_req = 1'b0; auto_drop = 1'b1;
    repeat (12) step();
    for (int k = 0; k < 5; k++) begin
      chk32($sformatf("t6_grant%0d", k), g_addr[g0+k],
            (Guard && k == 4) ? 32'h100 : 32'h200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
